// File: rtl/ir_a2d_sched_pkg.sv
// Shared types and constants for the IR line-sensor A2D scheduler.
// Pair table maps each emitter group to its channels, weight and enable.
package ir_a2d_sched_pkg;

  localparam int SETTLE_CYC_DEF = 4096;
  localparam int GAP_CYC_DEF    = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CNV_A,
    GAP,
    CNV_B,
    NEXT
  } state_e;

  typedef enum logic [1:0] {
    P_IN,
    P_MID,
    P_OUT
  } pair_e;

  localparam logic [2:0] CH_IN_A  = 3'd1;
  localparam logic [2:0] CH_IN_B  = 3'd0;
  localparam logic [2:0] CH_MID_A = 3'd4;
  localparam logic [2:0] CH_MID_B = 3'd2;
  localparam logic [2:0] CH_OUT_A = 3'd3;
  localparam logic [2:0] CH_OUT_B = 3'd7;

  localparam logic [2:0] W_IN  = 3'd1;
  localparam logic [2:0] W_MID = 3'd2;
  localparam logic [2:0] W_OUT = 3'd4;

  // en bit order is {out, mid, in}
  typedef struct packed {
    logic [2:0] ch_a;
    logic [2:0] ch_b;
    logic [2:0] wt;
    logic [2:0] en;
  } pair_cfg_t;

  function automatic pair_cfg_t pair_cfg(pair_e p);
    pair_cfg_t c;
    unique case (p)
      P_MID:   c = '{CH_MID_A, CH_MID_B, W_MID, 3'b010};
      P_OUT:   c = '{CH_OUT_A, CH_OUT_B, W_OUT, 3'b100};
      default: c = '{CH_IN_A, CH_IN_B, W_IN, 3'b001};
    endcase
    return c;
  endfunction

  function automatic logic [15:0] scale(logic [11:0] r,
                                        logic [2:0] w);
    return 16'(r) * 16'(w);
  endfunction

endpackage

// File: rtl/ir_a2d_sched_timer.sv
// Loadable down-counter; done is high whenever the count is zero.
// Loading N-1 yields exactly N cycles before done is seen.
module ir_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ld_i) begin
      cnt_q <= ld_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ir_a2d_sched.sv
// Sequences IR emitter pairs through the A2D and accumulates a
// weighted left-minus-right line-position error once per round.
module ir_a2d_sched
  import ir_a2d_sched_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int GAP_CYC    = GAP_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic        IR_in_en,
  output logic        IR_mid_en,
  output logic        IR_out_en,
  output logic [15:0] error,
  output logic        err_vld
);

  localparam int TMAX =
    (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int TW = $clog2(TMAX + 1);

  state_e             state_q;
  pair_e              pair_q;
  logic signed [15:0] acc_q;
  logic [15:0]        err_q;
  logic               vld_q;
  logic               strt_q;
  logic [2:0]         chnnl_q;
  logic [2:0]         en_q;
  logic               abort_q;

  logic               tmr_ld;
  logic [TW-1:0]      tmr_val;
  logic               tmr_done;
  logic               abort;
  pair_cfg_t          cfg;
  pair_e              nxt;
  logic signed [15:0] scaled;

  assign cfg    = pair_cfg(pair_q);
  assign nxt    = (pair_q == P_IN) ? P_MID : P_OUT;
  assign scaled = $signed(scale(res, cfg.wt));
  // a go drop during a conversion is remembered until cnv_cmplt
  assign abort  = abort_q | ~go;

  always_comb begin
    tmr_ld  = 1'b0;
    tmr_val = TW'(SETTLE_CYC - 1);
    unique case (state_q)
      IDLE:  tmr_ld = go;
      NEXT:  tmr_ld = go && (pair_q != P_OUT);
      CNV_A: begin
        if (cnv_cmplt && !abort) begin
          tmr_ld  = 1'b1;
          tmr_val = TW'(GAP_CYC - 1);
        end
      end
      default: ;
    endcase
  end

  ir_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (tmr_ld),
    .ld_val_i (tmr_val),
    .done_o   (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pair_q  <= P_IN;
      acc_q   <= '0;
      err_q   <= '0;
      vld_q   <= 1'b0;
      strt_q  <= 1'b0;
      chnnl_q <= '0;
      en_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      strt_q <= 1'b0;
      vld_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (go) begin
            acc_q   <= '0;
            pair_q  <= P_IN;
            en_q    <= pair_cfg(P_IN).en;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (!go) begin
            en_q    <= '0;
            state_q <= IDLE;
          end else if (tmr_done) begin
            strt_q  <= 1'b1;
            chnnl_q <= cfg.ch_a;
            state_q <= CNV_A;
          end
        end
        CNV_A: begin
          if (cnv_cmplt) begin
            abort_q <= 1'b0;
            if (abort) begin
              en_q    <= '0;
              state_q <= IDLE;
            end else begin
              acc_q   <= acc_q + scaled;
              state_q <= GAP;
            end
          end else begin
            abort_q <= abort;
          end
        end
        GAP: begin
          if (!go) begin
            en_q    <= '0;
            state_q <= IDLE;
          end else if (tmr_done) begin
            strt_q  <= 1'b1;
            chnnl_q <= cfg.ch_b;
            state_q <= CNV_B;
          end
        end
        CNV_B: begin
          if (cnv_cmplt) begin
            abort_q <= 1'b0;
            en_q    <= '0;
            if (abort) begin
              state_q <= IDLE;
            end else begin
              acc_q   <= acc_q - scaled;
              state_q <= NEXT;
            end
          end else begin
            abort_q <= abort;
          end
        end
        NEXT: begin
          if (!go) begin
            state_q <= IDLE;
          end else if (pair_q == P_OUT) begin
            err_q   <= acc_q;
            vld_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            pair_q  <= nxt;
            en_q    <= pair_cfg(nxt).en;
            state_q <= SETTLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign strt_cnv  = strt_q;
  assign chnnl     = chnnl_q;
  assign IR_in_en  = en_q[0];
  assign IR_mid_en = en_q[1];
  assign IR_out_en = en_q[2];
  assign error     = err_q;
  assign err_vld   = vld_q;

endmodule
